// File: rtl/cdc_bundle_src.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cdc_bundle_src                                               |
// | Description : Source half of a toggle-handshake multi-bit CDC. Captures a  |
// |               word on valid/ready, announces it with a request toggle and  |
// |               holds it until the synchronised ack toggle matches.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cdc_bundle_src #(
  parameter int WIDTH     = 8,
  parameter int TIMEOUT   = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 srcClk_i,
  input  logic                 srcRst_i,
  input  logic                 srcValid_i,
  output logic                 srcReady_o,
  input  logic [WIDTH-1:0]     srcData_i,
  output logic                 reqTgl_o,
  output logic [WIDTH-1:0]     xferData_o,
  input  logic                 ackTgl_i,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] xferCnt_o
);

  // Wait counter only needs to reach TIMEOUT-1; one bit when the check is off.
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   ack_match;
  logic   ack_done;

  // Handshake decode and next-state selection.
  always_comb begin
    state_nxt = state;
    ack_match = (ackTgl_i == reqTgl_o);
    accept    = (state == ST_IDLE) && srcValid_i;
    ack_done  = (state == ST_WAIT_ACK) && ack_match;
    if (accept) begin
      state_nxt = ST_WAIT_ACK;
    end else if (ack_done) begin
      state_nxt = ST_IDLE;
    end
  end

  // Ready/busy depend only on the state register so upstream sees no comb path.
  assign srcReady_o = (state == ST_IDLE);
  assign busy_o     = (state == ST_WAIT_ACK);

  // State register.
  always_ff @(posedge srcClk_i or posedge srcRst_i) begin
    if (srcRst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word capture and request toggle; the word is only written when accepted,
  // so it stays frozen for the destination for the whole WAIT_ACK period.
  always_ff @(posedge srcClk_i or posedge srcRst_i) begin
    if (srcRst_i) begin
      reqTgl_o   <= 1'b0;
      xferData_o <= '0;
    end else if (accept) begin
      reqTgl_o   <= ~reqTgl_o;
      xferData_o <= srcData_i;
    end
  end

  // Completed-transfer counter, wraps naturally.
  always_ff @(posedge srcClk_i or posedge srcRst_i) begin
    if (srcRst_i) begin
      xferCnt_o <= '0;
    end else if (ack_done) begin
      xferCnt_o <= xferCnt_o + 1'b1;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
      logic [WAIT_W-1:0] wait_cnt;

      // Count unmatched wait edges; flag (sticky) when the limit is reached.
      // The FSM keeps waiting so a late ack still completes.
      always_ff @(posedge srcClk_i or posedge srcRst_i) begin
        if (srcRst_i) begin
          wait_cnt  <= '0;
          timeout_o <= 1'b0;
        end else if (accept) begin
          wait_cnt <= '0;
        end else if ((state == ST_WAIT_ACK) && !ack_match) begin
          if (wait_cnt != {WAIT_W{1'b1}}) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          if (wait_cnt == WAIT_LIMIT) begin
            timeout_o <= 1'b1;
          end
        end
      end
    end else begin : g_no_timeout
      assign timeout_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
